seven_seg_scan: RTL and testbench

- Downstream display stage of the real-time clock.
- Consumes the six BCD digits produced by the clock core: seconds, minutes and hours, each as a left/right pair.
- Drives a six-digit, common-anode, time-multiplexed 7-segment display: one digit lit at a time, round-robin, at a parameterised dwell time.
- Captures a coherent snapshot of all six digits once per scan frame, so a rollover mid-frame never shows a torn time.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/bcd_to_seg.sv | 27 ++
 rtl/seven_seg_scan.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment display stage:
// digit indices, active-low glyph constants and digit-enable helper.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] IDX_RSEC = 3'd0;
  localparam logic [2:0] IDX_LSEC = 3'd1;
  localparam logic [2:0] IDX_RMIN = 3'd2;
  localparam logic [2:0] IDX_LMIN = 3'd3;
  localparam logic [2:0] IDX_RHR  = 3'd4;
  localparam logic [2:0] IDX_LHR  = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [5:0] AN_OFF    = 6'h3F;

  // One-hot-low digit enable; out-of-range indices light nothing.
  function automatic logic [5:0] an_onehot_low(input logic [2:0] idx);
    logic [5:0] an_v;
    case (idx)
      IDX_RSEC: an_v = 6'b111110;
      IDX_LSEC: an_v = 6'b111101;
      IDX_RMIN: an_v = 6'b111011;
      IDX_LMIN: an_v = 6'b110111;
      IDX_RHR:  an_v = 6'b101111;
      IDX_LHR:  an_v = 6'b011111;
      default:  an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low {g,f,e,d,c,b,a} glyph decoder;
// non-decimal codes render as a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Glyph lookup
  always_comb begin
    case (bcd)
      4'd0:    seg_n = 7'h40;
      4'd1:    seg_n = 7'h79;
      4'd2:    seg_n = 7'h24;
      4'd3:    seg_n = 7'h30;
      4'd4:    seg_n = 7'h19;
      4'd5:    seg_n = 7'h12;
      4'd6:    seg_n = 7'h02;
      4'd7:    seg_n = 7'h78;
      4'd8:    seg_n = 7'h00;
      4'd9:    seg_n = 7'h10;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Six-digit common-anode multiplexed display driver with per-frame snapshot.
// Optional colon blink on the decimal points when SEG_DP_BLINK_EN is defined.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 16667,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] left_seconds_in,
  input  logic [3:0] right_seconds_in,
  input  logic [3:0] left_minutes_in,
  input  logic [3:0] right_minutes_in,
  input  logic [3:0] left_hours_in,
  input  logic [3:0] right_hours_in,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic [2:0]       digit_idx_r;
  logic [3:0]       snap_r [NUM_DIGITS];
  logic             dwell_end_s;
  logic             frame_end_s;
  logic [3:0]       cur_bcd_s;
  logic [6:0]       glyph_s;
  logic [5:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;
  logic             dp_nxt_s;
  logic [5:0]       an_n_r;
  logic [6:0]       seg_n_r;
  logic             dp_n_r;

  assign dwell_end_s = (div_cnt_r == DIV_LAST);
  assign frame_end_s = dwell_end_s && (digit_idx_r == IDX_LHR);

  // Dwell counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (dwell_end_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Round-robin digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_idx_r <= IDX_RSEC;
    end else if (dwell_end_s) begin
      digit_idx_r <= (digit_idx_r == IDX_LHR) ? IDX_RSEC : digit_idx_r + 3'd1;
    end else begin
      digit_idx_r <= digit_idx_r;
    end
  end

  // Frame snapshot, taken on the same edge the index wraps to digit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_r[i] <= 4'd0;
    end else if (frame_end_s) begin
      snap_r[IDX_RSEC] <= right_seconds_in;
      snap_r[IDX_LSEC] <= left_seconds_in;
      snap_r[IDX_RMIN] <= right_minutes_in;
      snap_r[IDX_LMIN] <= left_minutes_in;
      snap_r[IDX_RHR]  <= right_hours_in;
      snap_r[IDX_LHR]  <= left_hours_in;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_r[i] <= snap_r[i];
    end
  end

  // Select the snapped digit currently being scanned
  always_comb begin
    case (digit_idx_r)
      IDX_RSEC: cur_bcd_s = snap_r[IDX_RSEC];
      IDX_LSEC: cur_bcd_s = snap_r[IDX_LSEC];
      IDX_RMIN: cur_bcd_s = snap_r[IDX_RMIN];
      IDX_LMIN: cur_bcd_s = snap_r[IDX_LMIN];
      IDX_RHR:  cur_bcd_s = snap_r[IDX_RHR];
      IDX_LHR:  cur_bcd_s = snap_r[IDX_LHR];
      default:  cur_bcd_s = 4'd0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (cur_bcd_s),
    .seg_n (glyph_s)
  );

  // Digit enable and glyph, with leading-zero blanking of the tens-of-hours digit
  always_comb begin
    an_nxt_s  = an_onehot_low(digit_idx_r);
    seg_nxt_s = glyph_s;
    if (BLANK_LZ && (digit_idx_r == IDX_LHR) && (snap_r[IDX_LHR] == 4'd0)) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_BLANK;
    end else begin
      an_nxt_s  = an_onehot_low(digit_idx_r);
      seg_nxt_s = glyph_s;
    end
  end

`ifdef SEG_DP_BLINK_EN
  logic toggle_r;

  // Colon phase flips whenever a new frame brings a different seconds digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_r <= 1'b0;
    end else if (frame_end_s && (right_seconds_in != snap_r[IDX_RSEC])) begin
      toggle_r <= ~toggle_r;
    end else begin
      toggle_r <= toggle_r;
    end
  end

  // Decimal point lights only at the colon positions
  always_comb begin
    if ((digit_idx_r == IDX_RMIN) || (digit_idx_r == IDX_RHR)) begin
      dp_nxt_s = ~toggle_r;
    end else begin
      dp_nxt_s = 1'b1;
    end
  end
`else
  assign dp_nxt_s = 1'b1;
`endif

  // Output registers: enables and segments switch on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_n_r  <= AN_OFF;
      seg_n_r <= SEG_BLANK;
      dp_n_r  <= 1'b1;
    end else begin
      an_n_r  <= an_nxt_s;
      seg_n_r <= seg_nxt_s;
      dp_n_r  <= dp_nxt_s;
    end
  end

  assign an_n  = an_n_r;
  assign seg_n = seg_n_r;
  assign dp_n  = dp_n_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (SCAN_DIV=4) against a cycle-count
// based display model; honours SEG_DP_BLINK_EN for the colon expectation.
module tb_seven_seg_scan;

  localparam int SD    = 4;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_d [6];
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         t_cyc;
  logic [3:0] m_snap [6];
  logic       m_tog;
  logic [5:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always #5 clk = ~clk;

  seven_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .left_seconds_in  (in_d[1]),
    .right_seconds_in (in_d[0]),
    .left_minutes_in  (in_d[3]),
    .right_minutes_in (in_d[2]),
    .left_hours_in    (in_d[5]),
    .right_hours_in   (in_d[4]),
    .an_n             (an_n),
    .seg_n            (seg_n),
    .dp_n             (dp_n)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (v < 4'd10) ? tab[v] : 7'h3F;
  endfunction

  // Model: the output after edge n shows the digit that was active during
  // cycle n-1 of the scan; snapshots land on every FRAME-th edge.
  task automatic advance();
    int p;
    int idx;
    p   = t_cyc % FRAME;
    idx = p / SD;
    if (idx == 5 && m_snap[5] == 4'd0) begin
      exp_an  = 6'h3F;
      exp_seg = 7'h7F;
    end else begin
      exp_an  = ~(6'b000001 << idx);
      exp_seg = glyph(m_snap[idx]);
    end
`ifdef SEG_DP_BLINK_EN
    exp_dp = (idx == 2 || idx == 4) ? ~m_tog : 1'b1;
`else
    exp_dp = 1'b1;
`endif
    @(posedge clk);
    t_cyc++;
    if (t_cyc % FRAME == 0) begin
      if (in_d[0] != m_snap[0]) m_tog = ~m_tog;
      for (int i = 0; i < 6; i++) m_snap[i] = in_d[i];
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    t_cyc = 0;
    m_tog = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
  endtask

  task automatic test_reset();
    repeat (7) advance();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", an_n, seg_n, dp_n);
    end
    release_reset();
    advance();
    n_tests++;
    if (an_n !== 6'b111110 || seg_n !== 7'h40 || dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got an=%h seg=%h dp=%b, want an=3e seg=40 dp=1", an_n, seg_n, dp_n);
    end
  endtask

  task automatic test_full_scan();
    for (int i = 0; i < 6; i++) in_d[i] = 4'(6 - i);
    repeat (2 * FRAME) begin
      advance();
      n_tests++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
        n_fail++;
        $display("FAIL full_scan t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_tear_free();
    in_d[0] = 4'd5;
    while (t_cyc % FRAME != 0) advance();
    while (t_cyc % FRAME != 3 * SD + 1) advance();
    in_d[0] = 4'd6;
    repeat (FRAME + 2) begin
      advance();
      n_tests++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
        n_fail++;
        $display("FAIL tear_free t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_blank_dash();
    int n_dark;
    in_d[5] = 4'd0;
    in_d[2] = 4'hC;
    while (t_cyc % FRAME != 0) advance();
    n_dark = 0;
    repeat (FRAME) begin
      advance();
      if (an_n === 6'h3F) n_dark++;
      n_tests++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
        n_fail++;
        $display("FAIL blank_dash t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
    end
    n_tests++;
    if (n_dark != SD) begin
      n_fail++;
      $display("FAIL blank_dwell: got %0d dark cycles, want %0d", n_dark, SD);
    end
  endtask

  task automatic test_blink();
    for (int f = 0; f < 6; f++) begin
      in_d[0] = 4'((in_d[0] + 4'd1) % 4'd10);
      repeat (FRAME) begin
        advance();
        n_tests++;
        if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
          n_fail++;
          $display("FAIL blink f=%0d t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                   f, t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (5 * FRAME) begin
      if ($urandom_range(0, 7) == 0) in_d[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
      advance();
      n_tests++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
        n_fail++;
        $display("FAIL random t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    for (int i = 0; i < 6; i++) in_d[i] = 4'($urandom_range(1, 9));
    repeat (FRAME + 2 * SD + 2) advance();
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_dwell: got an=%h seg=%h dp=%b, want an=3f seg=7f dp=1", an_n, seg_n, dp_n);
    end
    release_reset();
    repeat (2 * FRAME) begin
      advance();
      n_tests++;
      if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== exp_dp) begin
        n_fail++;
        $display("FAIL after_reset t=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 t_cyc, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 6; i++) in_d[i] = 4'd0;
    repeat (3) @(posedge clk);
    release_reset();
    test_reset();
    test_full_scan();
    test_tear_free();
    test_blank_dash();
    test_blink();
    test_random();
    test_reset_mid_dwell();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
